// File: rtl/pixel_frame_buffer_if.sv
// Bundle of controller, camera and grayscaler signals around the frame store.
// master: the side that requests operations, feeds camera beats and applies pause.
// slave:  the frame store itself.
interface pixel_frame_buffer_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              rw;
  logic              clear;
  logic              planar;
  logic              wr_valid;
  logic [DATA_W-1:0] data_in;
  logic              pause;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              done;

  modport master (
    output enable, rw, clear, planar, wr_valid, data_in, pause,
    input  data_out, rd_valid, busy, done
  );

  modport slave (
    input  enable, rw, clear, planar, wr_valid, data_in, pause,
    output data_out, rd_valid, busy, done
  );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Single-frame store between camera capture and grayscaler.
// Writes and clears walk the store in interleaved order; reads stream either
// interleaved (RGBRGB..) or planar (RR..GG..BB..) under pause back-pressure.
// Optional feature: define PFB_FRAME_CNT_EN to add a 16-bit completed-write
// frame counter output (frame_cnt).
module pixel_frame_buffer #(
  parameter int DATA_W   = 8,
  parameter int IMG_H    = 2,
  parameter int IMG_W    = 2,
  parameter int CHANNELS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_frame_buffer_if.slave   bus
`ifdef PFB_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int NPIX  = IMG_H * IMG_W;
  localparam int DEPTH = NPIX * CHANNELS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic              planar_q, planar_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              advance;
  logic              last_word;
  logic [AW-1:0]     addr;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  // Both orders share one address formula; only the counter stepping differs.
  assign addr      = AW'(pix_q) * AW'(CHANNELS) + AW'(ch_q);
  assign last_word = (pix_q == PW'(NPIX - 1)) && (ch_q == CW'(CHANNELS - 1));

  // Next-state, counter stepping and store write strobe.
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    ch_d      = ch_q;
    planar_d  = planar_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        pix_d = '0;
        ch_d  = '0;
        if (bus.enable) begin
          if (bus.clear) begin
            state_d = S_CLEAR;
          end else if (bus.rw) begin
            state_d = S_WRITE;
          end else begin
            state_d  = S_READ;
            planar_d = bus.planar;
          end
        end
      end
      S_WRITE: begin
        if (bus.wr_valid) begin
          mem_we    = 1'b1;
          mem_wdata = bus.data_in;
          advance   = 1'b1;
        end
      end
      S_READ: begin
        if (bus.pause) begin
          state_d = S_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.pause) begin
          state_d = S_READ;
        end
      end
      S_CLEAR: begin
        mem_we  = 1'b1;
        advance = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (last_word) begin
        pix_d   = '0;
        ch_d    = '0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else if (state_q == S_READ && planar_q) begin
        // Planar: pixel index is the inner loop, channel the outer.
        if (pix_q == PW'(NPIX - 1)) begin
          pix_d = '0;
          ch_d  = ch_q + CW'(1);
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end else begin
        // Interleaved: channel index is the inner loop.
        if (ch_q == CW'(CHANNELS - 1)) begin
          ch_d  = '0;
          pix_d = pix_q + PW'(1);
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
    end
  end

  // State, counters, latched read order and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pix_q    <= '0;
      ch_q     <= '0;
      planar_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      ch_q     <= ch_d;
      planar_q <= planar_d;
      done_q   <= done_d;
    end
  end

  // Frame storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr] <= mem_wdata;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.rd_valid = (state_q == S_READ);
  assign bus.data_out = (state_q == S_READ) ? mem_q[addr] : '0;
  assign bus.done     = done_q;

`ifdef PFB_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        frame_inc;

  assign frame_inc = advance && last_word && (state_q == S_WRITE);

  // Count completed write frames; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_inc) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed + randomized bench for pixel_frame_buffer (2x2 frame, 3 channels).
// Reference: a plain array holding the expected frame, and an arithmetic
// mapping from stream position to storage word for each read order.
module tb_pixel_frame_buffer;
  localparam int DW    = 8;
  localparam int NPIX  = 4;
  localparam int CH    = 3;
  localparam int DEPTH = NPIX * CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_frame_buffer_if #(.DATA_W(DW)) bus();

`ifdef PFB_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  pixel_frame_buffer #(
    .DATA_W(DW), .IMG_H(2), .IMG_W(2), .CHANNELS(CH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PFB_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  int tests  = 0;
  int failed = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wr_data [DEPTH];
  int ref_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream position k -> storage word, from the frame layout rules.
  function automatic int exp_addr(input int k, input bit pl);
    return pl ? ((k % NPIX) * CH + (k / NPIX)) : k;
  endfunction

  task automatic idle_inputs();
    bus.enable = 1'b0; bus.rw = 1'b0; bus.clear = 1'b0; bus.planar = 1'b0;
    bus.wr_valid = 1'b0; bus.data_in = '0; bus.pause = 1'b0;
  endtask

  task automatic start_op(input bit c, input bit r, input bit p);
    @(negedge clk);
    bus.enable = 1'b1; bus.clear = c; bus.rw = r; bus.planar = p;
    @(negedge clk);
    idle_inputs();
    chk("op_busy_rise", {31'd0, bus.busy}, 32'd1);
    chk("op_no_done_at_start", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic check_frame_cnt(input string tag);
`ifdef PFB_FRAME_CNT_EN
    chk(tag, {16'd0, frame_cnt}, ref_frames);
`else
    tag = tag;
`endif
  endtask

  // abort_at >= 0 pulses reset while that beat is being offered.
  task automatic do_write(input bit stalls, input bit noise, input int abort_at);
    int beats = 0;
    int cyc = 0;
    int bad = 0;
    start_op(1'b0, 1'b1, 1'b0);
    while (beats < DEPTH && cyc < 200) begin
      bus.wr_valid = stalls ? ($urandom_range(2) != 0) : 1'b1;
      bus.data_in  = bus.wr_valid ? wr_data[beats] : DW'($urandom);
      if (noise) begin
        bus.enable = $urandom_range(1) == 1;
        bus.clear  = $urandom_range(1) == 1;
        bus.rw     = $urandom_range(1) == 1;
        bus.pause  = $urandom_range(1) == 1;
      end
      if (beats == abort_at) begin
        bus.wr_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        bad = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("abort_no_done_after", bad, 0);
        ref_frames = 0;
        check_frame_cnt("abort_frame_cnt");
        $display("[TB] write aborted by reset at beat %0d", beats);
        return;
      end
      cyc++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      @(negedge clk);
      if (bus.wr_valid) begin
        ref_mem[beats] = wr_data[beats];
        beats++;
      end
    end
    idle_inputs();
    chk("wr_beats", beats, DEPTH);
    chk("wr_busy_during", bad, 0);
    chk("wr_done_pulse", {31'd0, bus.done}, 32'd1);
    chk("wr_busy_end", {31'd0, bus.busy}, 32'd0);
    if (!stalls) chk("wr_busy_cycles", cyc, DEPTH);
    ref_frames++;
    @(negedge clk);
    chk("wr_done_one_cycle", {31'd0, bus.done}, 32'd0);
    check_frame_cnt("wr_frame_cnt");
    $display("[TB] write: %0d beats in %0d busy cycles (stalls=%0d)", beats, cyc, stalls);
  endtask

  // mode 0: no pause, 1: random pause, 2: pause for 3 cycles at beat 5.
  task automatic do_read(input bit pl, input int mode, output int low);
    int k = 0;
    int cyc = 0;
    int paused = 0;
    int bad = 0;
    low = 0;
    start_op(1'b0, 1'b0, pl);
    while (k < DEPTH && cyc < 300) begin
      cyc++;
      case (mode)
        1: bus.pause = ($urandom_range(2) == 0);
        2: bus.pause = (k == 5 && paused < 3);
        default: bus.pause = 1'b0;
      endcase
      if (mode == 1) bus.wr_valid = $urandom_range(1) == 1;
      if (bus.pause) paused++;
      if (bus.done !== 1'b0) bad++;
      if (bus.rd_valid !== 1'b1) begin
        low++;
        if (bus.data_out !== '0) bad++;
      end else begin
        chk(pl ? "rd_planar_beat" : "rd_inter_beat", {24'd0, bus.data_out},
            {24'd0, ref_mem[exp_addr(k, pl)]});
        if (!bus.pause) k++;
      end
      @(negedge clk);
    end
    idle_inputs();
    chk("rd_beats", k, DEPTH);
    chk("rd_idle_outputs", bad, 0);
    chk("rd_done_pulse", {31'd0, bus.done}, 32'd1);
    chk("rd_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("rd_valid_end", {31'd0, bus.rd_valid}, 32'd0);
    $display("[TB] read: planar=%0d mode=%0d %0d beats, rd_valid low %0d cycles", pl, mode, k, low);
  endtask

  task automatic do_clear();
    int cyc = 0;
    start_op(1'b1, 1'b1, 1'b0);
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("clr_cycles", cyc, DEPTH);
    chk("clr_done_pulse", {31'd0, bus.done}, 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);
    check_frame_cnt("clr_frame_cnt");
    $display("[TB] clear: busy for %0d cycles", cyc);
  endtask

  initial begin
    int low;
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check_frame_cnt("rst_frame_cnt");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) wr_data[i] = DW'(8'h10 + i);
    do_write(1'b0, 1'b0, -1);
    do_read(1'b0, 0, low);
    chk("rd_inter_no_gaps", low, 0);
    do_read(1'b1, 0, low);
    chk("rd_planar_no_gaps", low, 0);
    do_read(1'b0, 2, low);
    chk("rd_pause_low_cycles", low, 3);

    do_clear();
    do_read(1'b0, 1, low);

    do_write(1'b0, 1'b0, 5);
    for (int i = 0; i < 5; i++) ref_mem[i] = wr_data[i];
    do_read(1'b0, 0, low);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) wr_data[i] = DW'($urandom);
      do_write(1'b1, 1'b1, -1);
      do_read(1'b0, 1, low);
      do_read(1'b1, 1, low);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
